// File: rtl/wca_port_interface.sv
// Responder end of the port command/status interface: accepts {addr, cmd} and
// moves fixed-length blocks between the addressed port and two host-side FIFOs.
module wca_port_interface #(
    parameter int unsigned NBITS_ADDR = 2,
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned BLOCK_LEN  = 4,
    parameter int unsigned FIFO_AW    = 3
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NBITS_ADDR+1:0]   pifCtrl,
    output logic [6:0]              pifStatus,
    output logic [NBITS_ADDR-1:0]   ioAddr,
    input  logic [WIDTH-1:0]        portDin,
    output logic [WIDTH-1:0]        portDout,
    input  logic                    hostRdEn,
    output logic [WIDTH-1:0]        hostRdData,
    output logic                    hostRdEmpty,
    input  logic                    hostWrEn,
    input  logic [WIDTH-1:0]        hostWrData,
    output logic                    hostWrFull
);

    localparam int unsigned CNT_W = $clog2(BLOCK_LEN + 1);
    localparam int unsigned PTR_W = FIFO_AW + 1;
    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_LEN);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RD    = 3'd1;
    localparam logic [2:0] S_WR    = 3'd2;
    localparam logic [2:0] S_FLUSH = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [1:0] CMD_IDLE  = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;

    logic [2:0]            state_q, state_d;
    logic                  armed_q, armed_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [NBITS_ADDR-1:0] io_addr_q, io_addr_d;
    logic [PTR_W-1:0]      rd_wp_q, rd_wp_d, rd_rp_q, rd_rp_d;
    logic [PTR_W-1:0]      wr_wp_q, wr_wp_d, wr_rp_q, wr_rp_d;
    logic [WIDTH-1:0]      rd_mem [DEPTH];
    logic [WIDTH-1:0]      wr_mem [DEPTH];

    logic [1:0]            cmd;
    logic [NBITS_ADDR-1:0] addr;
    logic                  rd_empty, rd_full, wr_empty, wr_full;
    logic                  rd_push, rd_pop, wr_push, wr_pop, rd_room, flush;
    logic                  io_busy;
    logic [2:0]            io_state;

    assign cmd  = pifCtrl[1:0];
    assign addr = pifCtrl[NBITS_ADDR+1:2];

    assign rd_empty = (rd_wp_q == rd_rp_q);
    assign rd_full  = (rd_wp_q[FIFO_AW] != rd_rp_q[FIFO_AW]) &&
                      (rd_wp_q[FIFO_AW-1:0] == rd_rp_q[FIFO_AW-1:0]);
    assign wr_empty = (wr_wp_q == wr_rp_q);
    assign wr_full  = (wr_wp_q[FIFO_AW] != wr_rp_q[FIFO_AW]) &&
                      (wr_wp_q[FIFO_AW-1:0] == wr_rp_q[FIFO_AW-1:0]);

    // Host side is frozen during the flush cycle
    assign rd_pop  = hostRdEn && !rd_empty && (state_q != S_FLUSH);
    assign wr_push = hostWrEn && !wr_full && (state_q != S_FLUSH);
    assign rd_room = !rd_full || rd_pop;

    // Next-state and transfer control
    always_comb begin
        state_d   = state_q;
        armed_d   = armed_q;
        cnt_d     = cnt_q;
        io_addr_d = io_addr_q;
        rd_push   = 1'b0;
        wr_pop    = 1'b0;
        flush     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd == CMD_IDLE) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    io_addr_d = addr;
                    cnt_d     = '0;
                    armed_d   = 1'b0;
                    if (cmd == CMD_READ)       state_d = S_RD;
                    else if (cmd == CMD_WRITE) state_d = S_WR;
                    else                       state_d = S_FLUSH;
                end
            end
            S_RD: begin
                if (rd_room) begin
                    rd_push = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_d == CNT_LAST) state_d = S_DONE;
                end
            end
            S_WR: begin
                if (!wr_empty) begin
                    wr_pop = 1'b1;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_d == CNT_LAST) state_d = S_DONE;
                end
            end
            S_FLUSH: begin
                flush   = 1'b1;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rd_wp_d = flush ? '0 : (rd_push ? rd_wp_q + PTR_W'(1) : rd_wp_q);
        rd_rp_d = flush ? '0 : (rd_pop  ? rd_rp_q + PTR_W'(1) : rd_rp_q);
        wr_wp_d = flush ? '0 : (wr_push ? wr_wp_q + PTR_W'(1) : wr_wp_q);
        wr_rp_d = flush ? '0 : (wr_pop  ? wr_rp_q + PTR_W'(1) : wr_rp_q);
    end

    // Status decode from registered state and live FIFO flags
    always_comb begin
        io_busy  = 1'b0;
        io_state = 3'h0;
        case (state_q)
            S_RD: begin
                io_busy  = 1'b1;
                io_state = rd_room ? 3'h1 : 3'h3;
            end
            S_WR: begin
                io_busy  = 1'b1;
                io_state = wr_empty ? 3'h4 : 3'h2;
            end
            S_FLUSH: begin
                io_busy  = 1'b1;
                io_state = 3'h5;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            armed_q   <= 1'b1;
            cnt_q     <= '0;
            io_addr_q <= '0;
            rd_wp_q   <= '0;
            rd_rp_q   <= '0;
            wr_wp_q   <= '0;
            wr_rp_q   <= '0;
        end else begin
            state_q   <= state_d;
            armed_q   <= armed_d;
            cnt_q     <= cnt_d;
            io_addr_q <= io_addr_d;
            rd_wp_q   <= rd_wp_d;
            rd_rp_q   <= rd_rp_d;
            wr_wp_q   <= wr_wp_d;
            wr_rp_q   <= wr_rp_d;
        end
    end

    // Storage arrays carry no reset; validity comes from the pointers
    always_ff @(posedge clock) begin
        if (rd_push) rd_mem[rd_wp_q[FIFO_AW-1:0]] <= portDin;
        if (wr_push) wr_mem[wr_wp_q[FIFO_AW-1:0]] <= hostWrData;
    end

    assign pifStatus   = {rd_full, wr_empty, io_busy, io_state, clock};
    assign ioAddr      = io_addr_q;
    assign portDout    = wr_mem[wr_rp_q[FIFO_AW-1:0]];
    assign hostRdData  = rd_mem[rd_rp_q[FIFO_AW-1:0]];
    assign hostRdEmpty = rd_empty;
    assign hostWrFull  = wr_full;

endmodule

// File: tb/tb_wca_port_interface.sv
// Directed bench for wca_port_interface: a BLOCK_LEN=4 instance for the main
// scenarios and a BLOCK_LEN=1 instance for the held-command retrigger case.
module tb_wca_port_interface;

    logic        clock;
    logic        reset;
    logic [3:0]  pif_ctrl;
    logic [6:0]  pif_status;
    logic [1:0]  io_addr;
    logic [15:0] port_din, port_dout;
    logic        host_rd_en, host_rd_empty;
    logic [15:0] host_rd_data;
    logic        host_wr_en, host_wr_full;
    logic [15:0] host_wr_data;

    logic [3:0]  b_ctrl;
    logic [6:0]  b_status;
    logic [1:0]  b_addr;
    logic [15:0] b_dout, b_rd_data;
    logic        b_rd_empty, b_wr_en, b_wr_full;
    logic [15:0] b_wr_data;

    int n_checks;
    int n_fail;

    wca_port_interface #(.NBITS_ADDR(2), .WIDTH(16), .BLOCK_LEN(4), .FIFO_AW(3)) dut (
        .clock(clock), .reset(reset), .pifCtrl(pif_ctrl), .pifStatus(pif_status),
        .ioAddr(io_addr), .portDin(port_din), .portDout(port_dout),
        .hostRdEn(host_rd_en), .hostRdData(host_rd_data), .hostRdEmpty(host_rd_empty),
        .hostWrEn(host_wr_en), .hostWrData(host_wr_data), .hostWrFull(host_wr_full)
    );

    wca_port_interface #(.NBITS_ADDR(2), .WIDTH(16), .BLOCK_LEN(1), .FIFO_AW(3)) dut1 (
        .clock(clock), .reset(reset), .pifCtrl(b_ctrl), .pifStatus(b_status),
        .ioAddr(b_addr), .portDin(16'h0000), .portDout(b_dout),
        .hostRdEn(1'b0), .hostRdData(b_rd_data), .hostRdEmpty(b_rd_empty),
        .hostWrEn(b_wr_en), .hostWrData(b_wr_data), .hostWrFull(b_wr_full)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Full unstalled READ of four words starting at base, then re-arm
    task automatic do_read(input logic [15:0] base);
        pif_ctrl = {2'd3, 2'b01};
        step();
        pif_ctrl = 4'h0;
        for (int i = 0; i < 4; i++) begin
            port_din = base + 16'(i);
            step();
        end
        repeat (2) step();
    endtask

    task automatic test_reset();
        #2;
        n_checks++; if (pif_status[4] !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", pif_status[4]); end
        n_checks++; if (pif_status[3:1] !== 3'h0) begin n_fail++; $display("FAIL reset_state: got %h expected 0", pif_status[3:1]); end
        n_checks++; if (pif_status[6:5] !== 2'b01) begin n_fail++; $display("FAIL reset_flags: got %b expected 01", pif_status[6:5]); end
        n_checks++; if (pif_status[0] !== 1'b0) begin n_fail++; $display("FAIL reset_clkbit: got %b expected 0", pif_status[0]); end
        n_checks++; if (host_rd_empty !== 1'b1 || host_wr_full !== 1'b0) begin n_fail++; $display("FAIL reset_host: got empty=%b full=%b expected 1/0", host_rd_empty, host_wr_full); end
        n_checks++; if (io_addr !== 2'd0) begin n_fail++; $display("FAIL reset_addr: got %0d expected 0", io_addr); end
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_read();
        pif_ctrl = {2'd2, 2'b01};
        step();
        pif_ctrl = 4'h0;
        n_checks++; if (io_addr !== 2'd2) begin n_fail++; $display("FAIL read_addr: got %0d expected 2", io_addr); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (pif_status[4:1] !== 4'b1001) begin n_fail++; $display("FAIL read_busy_state%0d: got %b expected 1001", i, pif_status[4:1]); end
            port_din = 16'h00A0 + 16'(i);
            step();
        end
        n_checks++; if (pif_status[4:1] !== 4'b0000) begin n_fail++; $display("FAIL read_done: got %b expected 0000", pif_status[4:1]); end
        repeat (2) step();
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (host_rd_empty !== 1'b0 || host_rd_data !== 16'h00A0 + 16'(i)) begin n_fail++; $display("FAIL read_pop%0d: got %h empty=%b expected %h", i, host_rd_data, host_rd_empty, 16'h00A0 + 16'(i)); end
            host_rd_en = 1'b1;
            step();
            host_rd_en = 1'b0;
        end
        n_checks++; if (host_rd_empty !== 1'b1) begin n_fail++; $display("FAIL read_drained: got %b expected 1", host_rd_empty); end
    endtask

    task automatic test_write();
        host_wr_en = 1'b1;
        host_wr_data = 16'h0011;
        step();
        host_wr_data = 16'h0022;
        step();
        host_wr_en = 1'b0;
        n_checks++; if (pif_status[5] !== 1'b0) begin n_fail++; $display("FAIL write_prefill: wrEmpty got %b expected 0", pif_status[5]); end
        pif_ctrl = {2'd1, 2'b10};
        step();
        pif_ctrl = 4'h0;
        n_checks++; if (io_addr !== 2'd1) begin n_fail++; $display("FAIL write_addr: got %0d expected 1", io_addr); end
        n_checks++; if (pif_status[4:1] !== 4'b1010 || port_dout !== 16'h0011) begin n_fail++; $display("FAIL write_w0: got st=%b dout=%h expected 1010/0011", pif_status[4:1], port_dout); end
        step();
        n_checks++; if (pif_status[4:1] !== 4'b1010 || port_dout !== 16'h0022) begin n_fail++; $display("FAIL write_w1: got st=%b dout=%h expected 1010/0022", pif_status[4:1], port_dout); end
        step();
        host_wr_en = 1'b1;
        host_wr_data = 16'h0033;
        n_checks++; if (pif_status[5:1] !== 5'b11100) begin n_fail++; $display("FAIL write_stall: got %b expected 11100", pif_status[5:1]); end
        step();
        host_wr_data = 16'h0044;
        n_checks++; if (pif_status[3:1] !== 3'h2 || port_dout !== 16'h0033) begin n_fail++; $display("FAIL write_w2: got st=%h dout=%h expected 2/0033", pif_status[3:1], port_dout); end
        step();
        host_wr_en = 1'b0;
        n_checks++; if (pif_status[3:1] !== 3'h2 || port_dout !== 16'h0044) begin n_fail++; $display("FAIL write_w3: got st=%h dout=%h expected 2/0044", pif_status[3:1], port_dout); end
        step();
        n_checks++; if (pif_status[5:1] !== 5'b10000) begin n_fail++; $display("FAIL write_done: got %b expected 10000", pif_status[5:1]); end
        repeat (2) step();
    endtask

    task automatic test_stall();
        do_read(16'h00B0);
        host_rd_en = 1'b1;
        repeat (2) step();
        host_rd_en = 1'b0;
        do_read(16'h00C0);
        pif_ctrl = {2'd1, 2'b01};
        step();
        pif_ctrl = 4'h0;
        port_din = 16'h00D0;
        step();
        port_din = 16'h00D1;
        step();
        n_checks++; if (pif_status[6] !== 1'b1 || pif_status[3:1] !== 3'h3) begin n_fail++; $display("FAIL stall_full: got rdFull=%b st=%h expected 1/3", pif_status[6], pif_status[3:1]); end
        port_din = 16'h00D2;
        step();
        n_checks++; if (pif_status[4:1] !== 4'b1011) begin n_fail++; $display("FAIL stall_hold: got %b expected 1011", pif_status[4:1]); end
        host_rd_en = 1'b1;
        #1;
        n_checks++; if (pif_status[3:1] !== 3'h1 || host_rd_data !== 16'h00B2) begin n_fail++; $display("FAIL stall_poproom: got st=%h head=%h expected 1/00B2", pif_status[3:1], host_rd_data); end
        step();
        port_din = 16'h00D3;
        n_checks++; if (pif_status[3:1] !== 3'h1 || host_rd_data !== 16'h00B3) begin n_fail++; $display("FAIL stall_pop2: got st=%h head=%h expected 1/00B3", pif_status[3:1], host_rd_data); end
        step();
        host_rd_en = 1'b0;
        n_checks++; if (pif_status[4] !== 1'b0 || pif_status[6] !== 1'b1) begin n_fail++; $display("FAIL stall_done: got busy=%b rdFull=%b expected 0/1", pif_status[4], pif_status[6]); end
        repeat (2) step();
        for (int i = 0; i < 8; i++) begin
            logic [15:0] exp;
            exp = (i < 4) ? 16'h00C0 + 16'(i) : 16'h00D0 + 16'(i - 4);
            n_checks++; if (host_rd_data !== exp) begin n_fail++; $display("FAIL stall_drain%0d: got %h expected %h", i, host_rd_data, exp); end
            host_rd_en = 1'b1;
            step();
            host_rd_en = 1'b0;
        end
        n_checks++; if (host_rd_empty !== 1'b1) begin n_fail++; $display("FAIL stall_empty: got %b expected 1", host_rd_empty); end
    endtask

    task automatic test_retrigger();
        b_wr_en = 1'b1;
        b_wr_data = 16'h0055;
        step();
        b_wr_data = 16'h0066;
        step();
        b_wr_en = 1'b0;
        b_ctrl = {2'd0, 2'b10};
        step();
        n_checks++; if (b_status[3:1] !== 3'h2 || b_dout !== 16'h0055) begin n_fail++; $display("FAIL retrig_first: got st=%h dout=%h expected 2/0055", b_status[3:1], b_dout); end
        step();
        n_checks++; if (b_status[4] !== 1'b0) begin n_fail++; $display("FAIL retrig_done: got busy=%b expected 0", b_status[4]); end
        repeat (2) step();
        n_checks++; if (b_status[5:4] !== 2'b00 || b_dout !== 16'h0066) begin n_fail++; $display("FAIL retrig_held: got wrEmpty/busy=%b head=%h expected 00/0066", b_status[5:4], b_dout); end
        b_ctrl = 4'h0;
        step();
        b_ctrl = {2'd0, 2'b10};
        step();
        b_ctrl = 4'h0;
        n_checks++; if (b_status[3:1] !== 3'h2 || b_dout !== 16'h0066) begin n_fail++; $display("FAIL retrig_reissue: got st=%h dout=%h expected 2/0066", b_status[3:1], b_dout); end
        step();
        n_checks++; if (b_status[5:4] !== 2'b10) begin n_fail++; $display("FAIL retrig_end: got %b expected 10", b_status[5:4]); end
        repeat (2) step();
    endtask

    task automatic test_flush();
        do_read(16'h00E0);
        host_wr_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            host_wr_data = 16'h0070 + 16'(i);
            step();
        end
        host_wr_en = 1'b0;
        n_checks++; if (pif_status[5] !== 1'b0 || host_wr_full !== 1'b0 || host_rd_empty !== 1'b0) begin n_fail++; $display("FAIL flush_pre: got wrEmpty=%b wrFull=%b rdEmpty=%b expected 0/0/0", pif_status[5], host_wr_full, host_rd_empty); end
        pif_ctrl = {2'd0, 2'b11};
        step();
        pif_ctrl = 4'h0;
        n_checks++; if (pif_status[4:1] !== 4'b1101) begin n_fail++; $display("FAIL flush_state: got %b expected 1101", pif_status[4:1]); end
        step();
        n_checks++; if (pif_status[5:1] !== 5'b10000 || host_rd_empty !== 1'b1) begin n_fail++; $display("FAIL flush_after: got %b rdEmpty=%b expected 10000/1", pif_status[5:1], host_rd_empty); end
        repeat (2) step();
        do_read(16'h00F0);
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (host_rd_data !== 16'h00F0 + 16'(i)) begin n_fail++; $display("FAIL flush_reread%0d: got %h expected %h", i, host_rd_data, 16'h00F0 + 16'(i)); end
            host_rd_en = 1'b1;
            step();
            host_rd_en = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        host_wr_en = 1'b1;
        host_wr_data = 16'h0099;
        step();
        host_wr_en = 1'b0;
        pif_ctrl = {2'd2, 2'b01};
        step();
        pif_ctrl = 4'h0;
        port_din = 16'h00A5;
        step();
        port_din = 16'h00A6;
        step();
        n_checks++; if (pif_status[4] !== 1'b1 || host_rd_empty !== 1'b0) begin n_fail++; $display("FAIL rstmid_pre: got busy=%b rdEmpty=%b expected 1/0", pif_status[4], host_rd_empty); end
        reset = 1'b1;
        #1;
        n_checks++; if (pif_status[6:1] !== 6'b010000) begin n_fail++; $display("FAIL rstmid_status: got %b expected 010000", pif_status[6:1]); end
        n_checks++; if (host_rd_empty !== 1'b1 || io_addr !== 2'd0) begin n_fail++; $display("FAIL rstmid_host: got rdEmpty=%b addr=%0d expected 1/0", host_rd_empty, io_addr); end
        step();
        reset = 1'b0;
        step();
        n_checks++; if (pif_status[4] !== 1'b0) begin n_fail++; $display("FAIL rstmid_after: got busy=%b expected 0", pif_status[4]); end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        reset = 1'b1;
        pif_ctrl = 4'h0;
        port_din = 16'h0;
        host_rd_en = 1'b0;
        host_wr_en = 1'b0;
        host_wr_data = 16'h0;
        b_ctrl = 4'h0;
        b_wr_en = 1'b0;
        b_wr_data = 16'h0;
        test_reset();
        test_read();
        test_write();
        test_stall();
        test_retrigger();
        test_flush();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wca_port_interface.md
Name: wca_port_interface

Overview:
- Responder end of the port command/status interface.
- Accepts {addr, cmd} from the port controller and executes fixed-length block transfers between the addressed port and the host.
- Words flow through two internal FIFOs: rd FIFO (port->host) and wr FIFO (host->port).
- Reports busy, state and FIFO-blocking flags back to the controller on pifStatus; pifStatus[0] is the shared clock.

Parameters:
- NBITS_ADDR, 2, port address width.
- WIDTH, 16, data word width.
- BLOCK_LEN, 4, words per READ/WRITE command (>=1).
- FIFO_AW, 3, FIFO address bits; each FIFO depth = 2^FIFO_AW.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- pifCtrl  in  NBITS_ADDR+2  {addr[NBITS_ADDR-1:0], cmd[1:0]} from the port controller.
- pifStatus  out  7  {rdFull, wrEmpty, ioBusy, ioState[2:0], clock}.
- ioAddr  out  NBITS_ADDR  address latched at command accept; selects the port data mux.
- portDin  in  WIDTH  data from the addressed port; captured while ioState==3'h1.
- portDout  out  WIDTH  head of the wr FIFO, presented to the port while ioState==3'h2.
- hostRdEn  in  1  pop the rd FIFO.
- hostRdData  out  WIDTH  rd FIFO head, first-word-fall-through.
- hostRdEmpty  out  1  rd FIFO empty.
- hostWrEn  in  1  push hostWrData into the wr FIFO.
- hostWrData  in  WIDTH  host write data.
- hostWrFull  out  1  wr FIFO full.

Behaviour:
- Commands: 2'b00 IDLE, 2'b01 READ (port->rd FIFO), 2'b10 WRITE (wr FIFO->port), 2'b11 FLUSH (clear both FIFOs).
- States: S_IDLE, S_RD, S_WR, S_FLUSH, S_DONE. Register `armed`; word counter cnt, width clog2(BLOCK_LEN+1).
- Reset (async): state=S_IDLE, armed=1, cnt=0, ioAddr=0, both FIFOs empty.
  - Outputs at reset: ioBusy=0, ioState=0, rdFull=0, wrEmpty=1, hostRdEmpty=1, hostWrFull=0.
  - Reset mid-transfer aborts immediately and discards all FIFO contents.
- S_IDLE:
  - cmd==IDLE sets armed=1.
  - If armed and cmd!=IDLE: latch ioAddr=addr, cnt=0, armed=0; go to S_RD/S_WR/S_FLUSH.
  - ioBusy rises on the next cycle (1-cycle latency, well inside the controller's 2 wait cycles).
- S_RD, each cycle:
  - If rd FIFO not full: push portDin, cnt++.
  - Full with a simultaneous hostRdEn pop counts as not full: push and pop both occur.
  - cnt reaching BLOCK_LEN moves to S_DONE.
- S_WR, each cycle:
  - If wr FIFO not empty: pop; portDout shows the popped word during that cycle; cnt++.
  - A simultaneous hostWrEn into an empty FIFO does not count (no fall-through bypass).
  - cnt reaching BLOCK_LEN moves to S_DONE.
- S_FLUSH: one cycle; resets both FIFO pointers; host push/pop that cycle is ignored; then S_DONE.
- S_DONE: one cycle, ioBusy=0, then S_IDLE. A new command is accepted only after cmd==IDLE has been seen, so a controller cmd still held after a short block cannot retrigger.
- ioBusy = (state is S_RD, S_WR or S_FLUSH).
- ioState[2:0]:
  - 3'h1 in S_RD with room; 3'h3 in S_RD stalled on full.
  - 3'h2 in S_WR with data; 3'h4 in S_WR stalled on empty.
  - 3'h5 in S_FLUSH; 3'h0 otherwise.
  - Combinational from registered state and FIFO flags.
- rdFull = rd FIFO full; wrEmpty = wr FIFO empty. Both are live in all states.
- Host-side overflow/underflow is ignored: push when full and pop when empty are no-ops, pointers unchanged.
- FIFO pointers are FIFO_AW+1 bits and wrap modulo 2^(FIFO_AW+1); full = MSBs differ and low bits equal.
- cmd changes while busy are ignored.

Test Plan (WIDTH=16, BLOCK_LEN=4, FIFO_AW=3):
- READ addr=2, portDin=0xA0..0xA3 on successive cycles -> ioAddr=2; ioBusy next cycle; ioState=1 for 4 cycles; S_DONE; host pops 0xA0,0xA1,0xA2,0xA3 in order.
- Host pushes 0x11,0x22, then WRITE -> portDout 0x11,0x22 with ioState=2, then ioState=4 and wrEmpty=1; host pushes 0x33,0x44 -> both transferred, completes, ioBusy=0.
- Rd FIFO pre-filled to 6 with no host pops, READ -> 2 words accepted, ioState=3 and rdFull=1; host pops 1 per cycle -> remaining 2 words accepted, block completes.
- WRITE held on pifCtrl for 3 cycles with BLOCK_LEN=1 and data present -> exactly one transfer; no retrigger until cmd returns to IDLE and is reissued.
- 5 words queued in wr FIFO, FLUSH -> ioState=5 for one cycle, then wrEmpty=1 and hostRdEmpty=1; READ issued afterwards works normally.
- Assert reset two words into a READ -> ioBusy=0, ioState=0, hostRdEmpty=1 immediately, without waiting for a clock edge.
